// File: rtl/mmio_uart_tx.sv
// ============================================================================
// mmio_uart_tx : memory-mapped 8N1 UART transmitter with TX FIFO and baud reg
// Revision     : 1.0
// ============================================================================
`default_nettype none

module mmio_uart_tx #(
   parameter int          FIFO_DEPTH     = 8,
   parameter logic [15:0] BAUD_DIV_RESET = 16'd868
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        sel_i,
   input  logic        enable_i,
   input  logic [3:0]  wstrb_i,
   input  logic [3:0]  addr_i,
   input  logic [31:0] wvalue_i,
   output logic [31:0] rvalue_o,
   output logic        tx_o
);

   localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int c_cnt_w = c_ptr_w + 1;

   localparam logic [1:0] c_reg_data   = 2'd0;
   localparam logic [1:0] c_reg_status = 2'd1;
   localparam logic [1:0] c_reg_baud   = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   state_t               r_state;
   logic [7:0]           r_mem [FIFO_DEPTH];
   logic [c_ptr_w-1:0]   r_wr_ptr;
   logic [c_ptr_w-1:0]   r_rd_ptr;
   logic [c_cnt_w-1:0]   r_count;
   logic                 r_ovf;
   logic [15:0]          r_baud;
   logic [15:0]          r_div_cnt;
   logic [15:0]          r_div_cur;
   logic [2:0]           r_bit_cnt;
   logic [7:0]           r_shift;

   logic        w_access;
   logic        w_write;
   logic        w_read;
   logic [1:0]  w_reg;
   logic        w_push;
   logic        w_push_ok;
   logic        w_pop;
   logic        w_full;
   logic        w_fifo_empty;
   logic        w_tx_empty;
   logic        w_ovf_clr;
   logic        w_bit_end;
   logic [15:0] w_baud_eff;
   logic [7:0]  w_head;
   logic [31:0] w_status;
   logic        w_unused;

   assign w_access     = sel_i & enable_i;
   assign w_write      = w_access & (|wstrb_i);
   assign w_read       = w_access & ~(|wstrb_i);
   assign w_reg        = addr_i[3:2];
   assign w_unused     = &{1'b0, addr_i[1:0], wvalue_i[31:16]};

   assign w_fifo_empty = (r_count == '0);
   assign w_full       = (r_count == c_cnt_w'(FIFO_DEPTH));
   assign w_tx_empty   = w_fifo_empty & (r_state == ST_IDLE);
   assign w_head       = r_mem[r_rd_ptr];

   assign w_push       = w_write & (w_reg == c_reg_data) & wstrb_i[0];
   assign w_ovf_clr    = w_write & (w_reg == c_reg_status) & wstrb_i[0] & wvalue_i[2];

   // r_div_cur holds the divisor latched at the start of the current bit,
   // so BAUD writes only take hold at the next bit boundary.
   assign w_baud_eff   = (r_baud == 16'd0) ? 16'd1 : r_baud;
   assign w_bit_end    = (r_div_cnt == (r_div_cur - 16'd1));

   assign w_pop        = ~w_fifo_empty &
                         ((r_state == ST_IDLE) | ((r_state == ST_STOP) & w_bit_end));
   // A pop in the same cycle frees a slot, so a push to a full FIFO still lands.
   assign w_push_ok    = w_push & (~w_full | w_pop);

   assign w_status     = {16'd0, 8'(r_count), 5'd0, r_ovf, w_tx_empty, w_full};

   always_ff @(posedge clk_i) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= wvalue_i[7:0];
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
         end
         case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + c_cnt_w'(1);
            2'b01:   r_count <= r_count - c_cnt_w'(1);
            default: r_count <= r_count;
         endcase
         if (w_push & w_full & ~w_pop) begin
            r_ovf <= 1'b1;
         end else if (w_ovf_clr) begin
            r_ovf <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_baud   <= BAUD_DIV_RESET;
         rvalue_o <= 32'd0;
      end else begin
         if (w_write && (w_reg == c_reg_baud)) begin
            if (wstrb_i[0]) r_baud[7:0]  <= wvalue_i[7:0];
            if (wstrb_i[1]) r_baud[15:8] <= wvalue_i[15:8];
         end
         if (w_read) begin
            case (w_reg)
               c_reg_status: rvalue_o <= w_status;
               c_reg_baud:   rvalue_o <= {16'd0, r_baud};
               default:      rvalue_o <= 32'd0;
            endcase
         end else begin
            rvalue_o <= 32'd0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state   <= ST_IDLE;
         tx_o      <= 1'b1;
         r_shift   <= 8'd0;
         r_bit_cnt <= 3'd0;
         r_div_cnt <= 16'd0;
         r_div_cur <= 16'd1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_pop) begin
                  r_shift   <= w_head;
                  tx_o      <= 1'b0;
                  r_div_cnt <= 16'd0;
                  r_div_cur <= w_baud_eff;
                  r_state   <= ST_START;
               end
            end
            ST_START: begin
               if (w_bit_end) begin
                  tx_o      <= r_shift[0];
                  r_bit_cnt <= 3'd0;
                  r_div_cnt <= 16'd0;
                  r_div_cur <= w_baud_eff;
                  r_state   <= ST_DATA;
               end else begin
                  r_div_cnt <= r_div_cnt + 16'd1;
               end
            end
            ST_DATA: begin
               if (w_bit_end) begin
                  r_div_cnt <= 16'd0;
                  r_div_cur <= w_baud_eff;
                  if (r_bit_cnt == 3'd7) begin
                     tx_o    <= 1'b1;
                     r_state <= ST_STOP;
                  end else begin
                     tx_o      <= r_shift[1];
                     r_shift   <= {1'b0, r_shift[7:1]};
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                  end
               end else begin
                  r_div_cnt <= r_div_cnt + 16'd1;
               end
            end
            ST_STOP: begin
               if (w_bit_end) begin
                  r_div_cnt <= 16'd0;
                  r_div_cur <= w_baud_eff;
                  // Back-to-back frames: go straight to the next start bit.
                  if (w_pop) begin
                     r_shift <= w_head;
                     tx_o    <= 1'b0;
                     r_state <= ST_START;
                  end else begin
                     tx_o    <= 1'b1;
                     r_state <= ST_IDLE;
                  end
               end else begin
                  r_div_cnt <= r_div_cnt + 16'd1;
               end
            end
            default: begin
               tx_o    <= 1'b1;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
// ============================================================================
// tb_mmio_uart_tx : randomized self-checking bench with a frame-level line model
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_mmio_uart_tx;

   localparam int DEPTH = 8;

   logic        clk_i = 1'b0;
   logic        rstn_i = 1'b0;
   logic        sel_i;
   logic        enable_i;
   logic [3:0]  wstrb_i;
   logic [3:0]  addr_i;
   logic [31:0] wvalue_i;
   logic [31:0] rvalue_o;
   logic        tx_o;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] wr_bytes [16];

   always #5 clk_i = ~clk_i;

   mmio_uart_tx #(
      .FIFO_DEPTH     (DEPTH),
      .BAUD_DIV_RESET (16'd868)
   ) dut (
      .clk_i    (clk_i),
      .rstn_i   (rstn_i),
      .sel_i    (sel_i),
      .enable_i (enable_i),
      .wstrb_i  (wstrb_i),
      .addr_i   (addr_i),
      .wvalue_i (wvalue_i),
      .rvalue_o (rvalue_o),
      .tx_o     (tx_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
   endtask

   // Ideal line level k cycles after the first write of a burst started from idle:
   // start bit from k=2, then acc contiguous 10-bit frames of d cycles per bit.
   function automatic logic exp_tx(input int k, input int d, input int acc);
      int frame;
      int pos;
      logic [7:0] b;
      if (k < 2) return 1'b1;
      frame = (k - 2) / (10 * d);
      if (frame >= acc) return 1'b1;
      pos = ((k - 2) % (10 * d)) / d;
      if (pos == 0) return 1'b0;
      if (pos == 9) return 1'b1;
      b = wr_bytes[frame];
      return b[pos-1];
   endfunction

   task automatic drive(input logic s, input logic e, input logic [3:0] st,
                        input logic [3:0] a, input logic [31:0] d);
      sel_i    = s;
      enable_i = e;
      wstrb_i  = st;
      addr_i   = a;
      wvalue_i = d;
   endtask

   task automatic bus_idle();
      drive(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] st);
      drive(1'b1, 1'b1, st, a, d);
      step();
      bus_idle();
   endtask

   task automatic bus_read(input logic [3:0] a, output logic [31:0] v);
      drive(1'b1, 1'b1, 4'h0, a, 32'h0);
      step();
      v = rvalue_o;
      bus_idle();
   endtask

   // n DATA writes on consecutive cycles from an idle transmitter; STATUS is
   // read right after the burst and around the end of the last stop bit.
   task automatic run_burst(input int d, input int n, input int max_k, input bit do_tail);
      int acc;
      int cnt_mid;
      int t_end;
      int lim;
      bit ov;
      logic [31:0] st_mid;
      logic [31:0] ov_bits;
      acc     = (n > DEPTH + 1) ? DEPTH + 1 : n;
      ov      = (n > acc);
      ov_bits = ov ? 32'h4 : 32'h0;
      cnt_mid = (n == 1) ? 1 : acc - 1;
      st_mid  = 32'(cnt_mid * 256) | ov_bits | ((cnt_mid == DEPTH) ? 32'h1 : 32'h0);
      t_end   = 2 + 10 * d * acc;
      lim     = do_tail ? t_end + 1 : max_k;
      for (int k = 0; k <= lim; k++) begin
         check("tx_line", {31'd0, tx_o}, {31'd0, exp_tx(k, d, acc)});
         if (k == n + 1) check("status_busy", rvalue_o, st_mid);
         if (do_tail && k == t_end) check("status_stop", rvalue_o, ov_bits);
         if (do_tail && k == t_end + 1) check("status_idle", rvalue_o, ov_bits | 32'h2);
         if (k < n)
            drive(1'b1, 1'b1, 4'h1, 4'h0, {$urandom() & 32'hFFFF_FF00} | {24'd0, wr_bytes[k]});
         else if (k == n || (do_tail && (k == t_end - 1 || k == t_end)))
            drive(1'b1, 1'b1, 4'h0, 4'h4, 32'h0);
         else
            bus_idle();
         step();
      end
      bus_idle();
   endtask

   task automatic ovf_clear_check(input logic [31:0] base);
      logic [31:0] v;
      bus_write(4'h4, 32'h3, 4'h1);
      bus_read(4'h4, v);
      check("ovf_kept", v, base | 32'h4);
      bus_write(4'h4, 32'h4, 4'h1);
      bus_read(4'h4, v);
      check("ovf_cleared", v, base);
   endtask

   initial begin
      logic [31:0] v;
      int dv;
      int deff;
      int n;

      bus_idle();
      rstn_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      check("reset_tx", {31'd0, tx_o}, 32'd1);
      check("reset_rvalue", rvalue_o, 32'd0);
      rstn_i = 1'b1;
      step();

      bus_read(4'h8, v);
      check("baud_reset", v, 32'd868);
      step();
      check("rvalue_clears", rvalue_o, 32'd0);
      drive(1'b0, 1'b1, 4'h0, 4'h8, 32'h0);
      step();
      check("read_unselected", rvalue_o, 32'd0);
      bus_idle();
      bus_read(4'h4, v);
      check("status_reset", v, 32'h2);
      bus_read(4'hC, v);
      check("read_reserved", v, 32'd0);
      bus_read(4'h0, v);
      check("read_data", v, 32'd0);

      bus_write(4'hC, 32'hFFFF_FFFF, 4'hF);
      bus_write(4'h0, 32'h0000_0055, 4'h2);
      bus_read(4'h4, v);
      check("no_push", v, 32'h2);
      bus_write(4'h8, 32'h0000_1234, 4'h2);
      bus_read(4'h8, v);
      check("baud_hi_byte", v, 32'h0000_1264);

      bus_write(4'h8, 32'h0000_0004, 4'h3);
      bus_read(4'h8, v);
      check("baud_4", v, 32'd4);
      wr_bytes[0] = 8'hA5;
      run_burst(4, 1, 0, 1'b1);

      bus_write(4'h8, 32'h0000_0002, 4'h3);
      wr_bytes[0] = 8'h00;
      wr_bytes[1] = 8'hFF;
      run_burst(2, 2, 0, 1'b1);

      for (int it = 0; it < 8; it++) begin
         dv   = $urandom_range(0, 4);
         deff = (dv == 0) ? 1 : dv;
         n    = $urandom_range(1, 10);
         for (int i = 0; i < 16; i++) wr_bytes[i] = 8'($urandom());
         bus_write(4'h8, 32'(dv), 4'h3);
         run_burst(deff, n, 0, 1'b1);
         if (n > DEPTH + 1) ovf_clear_check(32'h2);
      end

      // Slow baud: fill and overflow, then reset in the middle of data bit 3.
      bus_write(4'h8, 32'd1000, 4'h3);
      for (int i = 0; i < 16; i++) wr_bytes[i] = 8'($urandom());
      run_burst(1000, 10, 2 + 1000 + 3000 + 500, 1'b0);
      ovf_clear_check(32'h0000_0801);
      check("before_abort", {31'd0, tx_o}, {31'd0, wr_bytes[0][3]});
      rstn_i = 1'b0;
      #1;
      check("abort_tx", {31'd0, tx_o}, 32'd1);
      step();
      step();
      rstn_i = 1'b1;
      step();
      bus_read(4'h4, v);
      check("status_after_abort", v, 32'h2);
      check("tx_after_abort", {31'd0, tx_o}, 32'd1);
      bus_read(4'h8, v);
      check("baud_after_abort", v, 32'd868);

      bus_write(4'h8, 32'd1, 4'h3);
      wr_bytes[0] = 8'($urandom());
      run_burst(1, 1, 0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
